fp_mul_pipe: RTL
================

# fp_mul_pipe

Parametrised, fully pipelined IEEE-754-style floating-point multiplier with a valid/ready stream interface, round-to-nearest-even and exception flags. It supersedes the fixed single-precision multiplier. It supports any exponent/mantissa split, handles zero/inf/NaN/overflow/underflow, and accepts one operation per cycle with backpressure. It sits in the arithmetic datapath between operand issue and result writeback.

## Interface
- EXP_W, 8, exponent field width (≥4)
- MAN_W, 23, stored mantissa width, hidden bit excluded (≥4)
- clk  in  1  clock, all state on rising edge
- resetn  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept this cycle
- in_a, in_b  in  1+EXP_W+MAN_W  operands {sign, exp, man}
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_z  out  1+EXP_W+MAN_W  product
- out_flags  out  4  {invalid, overflow, underflow, inexact}, qualified by out_valid

## Operation
- Transfer on in_valid&in_ready (input) and on out_valid&out_ready (output).
- Stage S1: unpack and classify (zero = exp 0, covering denormals, which are flushed to zero; inf = exp all-ones with man 0; NaN = exp all-ones with man≠0). Sign = sa^sb. Signed exponent e = ea+eb−BIAS in EXP_W+2 bits, where BIAS = 2^(EXP_W−1)−1.
- Stage S2: (MAN_W+1)×(MAN_W+1) unsigned product P, width 2·MAN_W+2.
- Stage S3, normalise:
  - If P MSB is set: e+=1 and take mantissa from the bits below the MSB.
  - Otherwise take mantissa from one bit lower.
  - Guard G = first dropped bit; sticky S = OR of the remaining dropped bits.
- Stage S3, round: round up iff G&(S|LSB). A mantissa carry-out sets man=0 and e+=1.
- Stage S3, pack, in priority order:
  1. NaN input, or inf×zero: canonical qNaN {0, all-ones, 1, 0…}. Sets invalid only for inf×zero.
  2. inf input: signed inf.
  3. zero input: signed zero, no flags.
  4. e ≥ 2^EXP_W−1: signed inf, overflow=1, inexact=1.
  5. e ≤ 0: signed zero, underflow=1, inexact=1.
  6. Otherwise: normal result, inexact = G|S.
- Flow control is a global stall:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - While stalled, every stage register holds.
  - Bubbles (invalid stages) propagate; they are not compressed.

## Timing
- Latency is exactly 3 cycles from input transfer to out_valid, absent stalls. Each stall cycle adds 1.
- Throughput is 1 op/cycle with out_ready held high.
- Results leave in acceptance order; nothing is dropped or duplicated under any stall pattern.
- Reset values: out_valid=0, out_z=0, out_flags=0, all stage valid bits 0.
- in_ready is 1 during reset, but no transfer occurs while resetn is low.
- Reset mid-operation: in-flight ops are discarded and out_valid drops asynchronously.
- out_z and out_flags are stable while out_valid&~out_ready.
- in_ready depends combinationally on out_ready. No other comb path runs from input to output.

## Configuration
- FP_MUL_RNE_EN defined: round-to-nearest-even as described.
- FP_MUL_RNE_EN undefined: truncate (never round up, so no rounding carry).
- In both modes, the inexact, overflow and underflow rules are unchanged.

## Test plan
All scenarios use EXP_W=8, MAN_W=23.
- 0x3FC00000 × 0x40000000 → 0x40400000, flags 0000, out_valid exactly 3 cycles after acceptance.
- Tie rounding, 0x3F800001 × 0x3FC00000:
  - RNE build → 0x3FC00002, inexact=1.
  - Truncate build → 0x3FC00001, inexact=1.
- Specials:
  - 0x7F800000 × 0x00000000 → 0x7FC00000, invalid=1.
  - 0x7F000000 × 0x7F000000 → 0x7F800000, overflow=1, inexact=1.
  - 0x00800000 × 0x00800000 → 0x00000000, underflow=1.
  - 0x80000000 × 0x40000000 → 0x80000000, flags 0.
- Backpressure:
  - Issue 6 back-to-back ops and hold out_ready=0 for cycles 4–7.
  - in_ready=0 exactly while out_valid&~out_ready.
  - All 6 results arrive in order and unchanged.
- Reset mid-flight: pull resetn low with 3 ops in flight → out_valid=0 immediately; after release, no stale results ever appear.
- Random: 10k random normal operands with random out_ready → results match a bit-exact reference model in each build.

Source files
------------

// File: rtl/fp_mul_if.sv
// Operand/result stream bundle for fp_mul_pipe: valid/ready on both sides.
// master = operand issuer / result consumer, slave = the multiplier.
interface fp_mul_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_z;
    logic [3:0]   out_flags;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_z, out_flags
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_z, out_flags
    );
endinterface

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier (unpack / multiply / normalise-round-pack).
// Define FP_MUL_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic     clk,
    input  logic     resetn,
    fp_mul_if.slave  bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;
    localparam logic signed [EW-1:0] BIAS    = EW'((2 ** (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_TOP = EW'((2 ** EXP_W) - 1);

    logic stall;

    // Stage 1 state
    logic                 s1_valid_reg, s1_sign_reg;
    logic signed [EW-1:0] s1_exp_reg;
    logic [MAN_W:0]       s1_ma_reg, s1_mb_reg;
    logic                 s1_nan_reg, s1_invalid_reg, s1_inf_reg, s1_zero_reg;

    // Stage 2 state
    logic                 s2_valid_reg, s2_sign_reg;
    logic signed [EW-1:0] s2_exp_reg;
    logic [PW-1:0]        s2_prod_reg;
    logic                 s2_nan_reg, s2_invalid_reg, s2_inf_reg, s2_zero_reg;

    // Output state
    logic                 out_valid_reg;
    logic [W-1:0]         out_z_reg;
    logic [3:0]           out_flags_reg;

    assign stall         = out_valid_reg & ~bus.out_ready;
    assign bus.in_ready  = ~stall;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_z     = out_z_reg;
    assign bus.out_flags = out_flags_reg;

    // Unpack and classify; denormals fall into the zero class.
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign ea     = bus.in_a[W-2:MAN_W];
    assign eb     = bus.in_b[W-2:MAN_W];
    assign fa     = bus.in_a[MAN_W-1:0];
    assign fb     = bus.in_b[MAN_W-1:0];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == '1) && (fa == '0);
    assign b_inf  = (eb == '1) && (fb == '0);
    assign a_nan  = (ea == '1) && (fa != '0);
    assign b_nan  = (eb == '1) && (fb != '0);

    // Normalise, round and pack from stage 2.
    logic                 msb, guard, sticky, round_up, carry;
    logic [MAN_W-1:0]     man_n, man_r;
    logic signed [EW-1:0] exp_n, exp_r;
    logic [W-1:0]         z_next;
    logic [3:0]           flags_next;

    always_comb begin
        msb    = s2_prod_reg[PW-1];
        man_n  = msb ? s2_prod_reg[PW-2 -: MAN_W] : s2_prod_reg[PW-3 -: MAN_W];
        guard  = msb ? s2_prod_reg[MAN_W] : s2_prod_reg[MAN_W-1];
        sticky = msb ? |s2_prod_reg[MAN_W-1:0] : |s2_prod_reg[MAN_W-2:0];
        exp_n  = s2_exp_reg + {{(EW-1){1'b0}}, msb};
`ifdef FP_MUL_RNE_EN
        round_up = guard & (sticky | man_n[0]);
`else
        round_up = 1'b0;
`endif
        {carry, man_r} = {1'b0, man_n} + {{MAN_W{1'b0}}, round_up};
        exp_r = exp_n + {{(EW-1){1'b0}}, carry};

        z_next     = {s2_sign_reg, exp_r[EXP_W-1:0], man_r};
        flags_next = {3'b000, guard | sticky};
        if (s2_nan_reg) begin
            z_next     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            flags_next = {s2_invalid_reg, 3'b000};
        end else if (s2_inf_reg) begin
            z_next     = {s2_sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_next = 4'b0000;
        end else if (s2_zero_reg) begin
            z_next     = {s2_sign_reg, {(W-1){1'b0}}};
            flags_next = 4'b0000;
        end else if (exp_r >= EXP_TOP) begin
            z_next     = {s2_sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_next = 4'b0101;
        end else if (exp_r <= 0) begin
            z_next     = {s2_sign_reg, {(W-1){1'b0}}};
            flags_next = 4'b0011;
        end
    end

    // Global stall: every stage holds while the output is blocked.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid_reg   <= 1'b0;
            s1_sign_reg    <= 1'b0;
            s1_exp_reg     <= '0;
            s1_ma_reg      <= '0;
            s1_mb_reg      <= '0;
            s1_nan_reg     <= 1'b0;
            s1_invalid_reg <= 1'b0;
            s1_inf_reg     <= 1'b0;
            s1_zero_reg    <= 1'b0;
            s2_valid_reg   <= 1'b0;
            s2_sign_reg    <= 1'b0;
            s2_exp_reg     <= '0;
            s2_prod_reg    <= '0;
            s2_nan_reg     <= 1'b0;
            s2_invalid_reg <= 1'b0;
            s2_inf_reg     <= 1'b0;
            s2_zero_reg    <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_z_reg      <= '0;
            out_flags_reg  <= '0;
        end else if (!stall) begin
            s1_valid_reg   <= bus.in_valid;
            s1_sign_reg    <= bus.in_a[W-1] ^ bus.in_b[W-1];
            s1_exp_reg     <= {2'b00, ea} + {2'b00, eb} - BIAS;
            s1_ma_reg      <= {1'b1, fa};
            s1_mb_reg      <= {1'b1, fb};
            s1_invalid_reg <= (a_inf & b_zero) | (b_inf & a_zero);
            s1_nan_reg     <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
            s1_inf_reg     <= a_inf | b_inf;
            s1_zero_reg    <= a_zero | b_zero;

            s2_valid_reg   <= s1_valid_reg;
            s2_sign_reg    <= s1_sign_reg;
            s2_exp_reg     <= s1_exp_reg;
            s2_prod_reg    <= {{(MAN_W+1){1'b0}}, s1_ma_reg} * {{(MAN_W+1){1'b0}}, s1_mb_reg};
            s2_nan_reg     <= s1_nan_reg;
            s2_invalid_reg <= s1_invalid_reg;
            s2_inf_reg     <= s1_inf_reg;
            s2_zero_reg    <= s1_zero_reg;

            out_valid_reg  <= s2_valid_reg;
            out_z_reg      <= z_next;
            out_flags_reg  <= flags_next;
        end
    end
endmodule
